dot_product_accumulator: RTL and testbench
==========================================

Name: dot_product_accumulator

Overview:
- Downstream consumer of the 32x32 sequential signed multiplier. Accepts a burst of 64-bit signed products and sums them in a wide accumulator.
- Rounds and right-shifts the sum to a fixed-point output, then saturates it to OUT_W bits.
- Presents the result on a valid/ready output port and holds it under backpressure. Used to build dot products and FIR taps from the serial multiplier.

Parameters:
- PROD_W, 64: width of each incoming signed product.
- LEN_W, 8: width of the burst-length field. Maximum burst is 2^LEN_W - 1 products.
- ACC_W, 72: accumulator width. Must satisfy ACC_W >= PROD_W + LEN_W, so the accumulator can never overflow.
- OUT_W, 32: signed output width.
- SHIFT, 16: fraction bits dropped at output. Range is 0 to ACC_W - OUT_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a burst. Sampled only in IDLE.
- len  in  LEN_W  number of products in the burst, unsigned. Sampled with start.
- in_valid  in  1  in_prod is valid this cycle.
- in_ready  out  1  block accepts in_prod this cycle.
- in_prod  in  PROD_W  signed product from the multiplier.
- out_valid  out  1  out_sum and out_sat are valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  OUT_W  rounded, shifted, saturated sum, signed.
- out_sat  out  1  result was clipped to the positive or negative limit.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: single clock. rst is synchronous and active-high.
- Reset values: state is IDLE; accumulator, counter, out_sum and out_sat are 0; out_valid, in_ready and busy are 0. Reset has priority over every other input in any state, including mid-burst and mid-HOLD. Any partial sum is discarded.
- FSM states are IDLE, ACCUM, ROUND and HOLD. All outputs are registered except in_ready, which is decoded from state (in_ready = state==ACCUM).
- IDLE:
  - start=1 clears the accumulator and loads the counter with len.
  - len != 0 goes to ACCUM. len == 0 goes straight to ROUND, producing a sum of 0.
  - in_valid is ignored here, including when it coincides with start.
- ACCUM:
  - A handshake (in_valid & in_ready) adds sign-extended in_prod to the accumulator and decrements the counter.
  - On the handshake that brings the counter to 0, go to ROUND.
  - Cycles with in_valid=0 are stalls and leave state unchanged. Gaps between products are unlimited.
  - start is ignored.
- ROUND, one cycle:
  - If SHIFT > 0: r = (acc + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, i.e. round half toward +infinity. If SHIFT = 0: r = acc.
  - The addition is done at ACC_W+1 bits so it cannot wrap.
  - If r > 2^(OUT_W-1)-1: out_sum = 2^(OUT_W-1)-1 and out_sat=1.
  - If r < -2^(OUT_W-1): out_sum = -2^(OUT_W-1) and out_sat=1.
  - Otherwise out_sum = r[OUT_W-1:0] and out_sat=0.
  - Set out_valid=1 and go to HOLD.
- HOLD:
  - out_valid=1. out_sum and out_sat stay stable until out_valid & out_ready.
  - On that handshake: out_valid=0, go to IDLE. A start in the same cycle is ignored; start is honoured from the next cycle onward.
- Latency:
  - Handshake of the last product at cycle t: ROUND at t+1, out_valid high from t+2.
  - len==0 with start at cycle t: out_valid high from t+2.
  - With out_ready held at 1, the minimum burst-to-burst overhead is 3 cycles plus len product cycles.
- Throughput: one product per cycle in ACCUM.

Test Plan:
- Basic sum: len=3; products 0x10000, 0x20000, -0x10000 back-to-back; out_ready=1. Required: out_sum=2, out_sat=0, out_valid rises exactly 2 cycles after the 3rd handshake and lasts 1 cycle.
- Rounding, one len=1 burst each:
  - prod 0x8000 gives out_sum=1.
  - prod 0x7FFF gives 0.
  - prod -0x8000 gives 0.
  - prod -0x8001 gives -1.
  - prod -0x18000 gives -1.
- Saturation:
  - len=2, both products 0x7FFF_FFFF_FFFF_FFFF: out_sum=0x7FFFFFFF, out_sat=1.
  - len=2, both products 0x8000_0000_0000_0000: out_sum=0x80000000, out_sat=1.
- Backpressure and ignored inputs: complete a burst, then hold out_ready=0 for 5 cycles while pulsing start and driving in_valid. Required: out_valid and out_sum constant, in_ready=0, busy=1, no new burst starts. Raise out_ready: IDLE the next cycle.
- Stalls and zero-length:
  - len=4 with in_valid gaps of 0, 3 and 1 cycles between products 1, 2, 3 and 4 (each 0x10000): out_sum=4.
  - len=0: out_sum=0, out_valid 2 cycles after start.
- Reset mid-operation: assert rst after 2 of 4 products accepted. Required: all outputs 0 and state IDLE the next cycle. A fresh len=1 burst with prod 0x30000 then gives out_sum=3, proving the partial sum was discarded.

Source files
------------

// File: rtl/dot_product_accumulator_if.sv
// Handshake bundle between the serial multiplier, the dot-product accumulator and its consumer.
// The master side drives bursts and accepts results; the slave side is the accumulator.
interface dot_product_accumulator_if #(
    parameter int PROD_W = 64,
    parameter int LEN_W  = 8,
    parameter int OUT_W  = 32
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_sum;
    logic              out_sat;
    logic              busy;

    modport master (
        output start, len, in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_sum, out_sat, busy
    );

    modport slave (
        input  start, len, in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_sum, out_sat, busy
    );
endinterface

// File: rtl/dot_product_accumulator.sv
// Sums a burst of signed products, then rounds, shifts and saturates the total
// to a fixed-point result held on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for start; len captured with it
// ACCUM | adding products until the burst count reaches zero
// ROUND | one cycle: round, shift and saturate the sum
// HOLD  | result presented until out_ready
module dot_product_accumulator #(
    parameter int PROD_W = 64,
    parameter int LEN_W  = 8,
    parameter int ACC_W  = 72,
    parameter int OUT_W  = 32,
    parameter int SHIFT  = 16
) (
    input logic clk,
    input logic rst,
    dot_product_accumulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, ROUND, HOLD} state_t;

    // Half an output LSB; collapses to zero when no fraction bits are dropped.
    localparam logic [ACC_W:0] RND_INC = ({{ACC_W{1'b0}}, 1'b1} << SHIFT) >> 1;
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic        [LEN_W-1:0]  cnt;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W:0]    r;

    assign prod_ext     = {{(ACC_W-PROD_W){bus.in_prod[PROD_W-1]}}, bus.in_prod};
    // One extra bit so the rounding increment can never wrap the sum.
    assign r            = $signed({acc[ACC_W-1], acc} + RND_INC) >>> SHIFT;
    assign bus.in_ready = (state == ACCUM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            bus.out_sum   <= '0;
            bus.out_sat   <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc      <= '0;
                        cnt      <= bus.len;
                        bus.busy <= 1'b1;
                        state    <= (bus.len != '0) ? ACCUM : ROUND;
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc <= acc + prod_ext;
                        cnt <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1))
                            state <= ROUND;
                    end
                end
                ROUND: begin
                    if (r > SAT_MAX) begin
                        bus.out_sum <= SAT_MAX[OUT_W-1:0];
                        bus.out_sat <= 1'b1;
                    end else if (r < SAT_MIN) begin
                        bus.out_sum <= SAT_MIN[OUT_W-1:0];
                        bus.out_sat <= 1'b1;
                    end else begin
                        bus.out_sum <= r[OUT_W-1:0];
                        bus.out_sat <= 1'b0;
                    end
                    bus.out_valid <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator: expected results are queued when a
// burst is driven and compared when the accumulator presents its output.
module tb_dot_product_accumulator;
    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   ref_cyc;

    typedef struct packed {
        logic [31:0] sum;
        logic        sat;
    } exp_t;
    exp_t sb[$];

    dot_product_accumulator_if #(.PROD_W(64), .LEN_W(8), .OUT_W(32)) bus ();

    dot_product_accumulator #(
        .PROD_W(64), .LEN_W(8), .ACC_W(72), .OUT_W(32), .SHIFT(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_burst(input logic [7:0] n);
        bus.start = 1'b1;
        bus.len   = n;
        ref_cyc   = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [63:0] prod, input int gap);
        int n;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_prod  = prod;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        ref_cyc = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input bit check_lat, input bit check_drop);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check({tag, "_timeout"}, 64'(bus.out_valid), 64'd1);
        if (check_lat) check({tag, "_latency"}, 64'(cyc - ref_cyc), 64'd2);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_sum"}, 64'(bus.out_sum), 64'(e.sum));
            check({tag, "_sat"}, 64'(bus.out_sat), 64'(e.sat));
        end
        if (check_drop) begin
            @(negedge clk);
            check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
            check({tag, "_busy_drop"}, 64'(bus.busy), 64'd0);
        end
    endtask

    task automatic one_shot(input string tag, input logic [63:0] prod, input logic [31:0] sum,
                            input logic sat);
        sb.push_back('{sum: sum, sat: sat});
        start_burst(8'd1);
        send(prod, 0);
        expect_result(tag, 1'b1, 1'b1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_prod   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_out_sum", 64'(bus.out_sum), 64'd0);
        check("rst_out_sat", 64'(bus.out_sat), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic three-product burst.
        sb.push_back('{sum: 32'd2, sat: 1'b0});
        start_burst(8'd3);
        check("accum_in_ready", 64'(bus.in_ready), 64'd1);
        send(64'h10000, 0);
        send(64'h20000, 0);
        send(-64'sh10000, 0);
        expect_result("basic", 1'b1, 1'b1);

        one_shot("rnd_p8000", 64'h8000, 32'd1, 1'b0);
        one_shot("rnd_p7fff", 64'h7FFF, 32'd0, 1'b0);
        one_shot("rnd_m8000", -64'sh8000, 32'd0, 1'b0);
        one_shot("rnd_m8001", -64'sh8001, 32'hFFFF_FFFF, 1'b0);
        one_shot("rnd_m18000", -64'sh18000, 32'hFFFF_FFFF, 1'b0);

        sb.push_back('{sum: 32'h7FFF_FFFF, sat: 1'b1});
        start_burst(8'd2);
        send(64'h7FFF_FFFF_FFFF_FFFF, 0);
        send(64'h7FFF_FFFF_FFFF_FFFF, 0);
        expect_result("sat_pos", 1'b1, 1'b1);

        sb.push_back('{sum: 32'h8000_0000, sat: 1'b1});
        start_burst(8'd2);
        send(64'h8000_0000_0000_0000, 0);
        send(64'h8000_0000_0000_0000, 0);
        expect_result("sat_neg", 1'b1, 1'b1);

        // Backpressure with start and in_valid activity that must be ignored.
        sb.push_back('{sum: 32'd5, sat: 1'b0});
        bus.out_ready = 1'b0;
        start_burst(8'd1);
        send(64'h50000, 0);
        expect_result("bp", 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.start    = 1'b1;
            bus.len      = 8'd2;
            bus.in_valid = 1'b1;
            bus.in_prod  = 64'h70000;
            @(negedge clk);
            check($sformatf("bp_valid_%0d", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("bp_sum_%0d", i), 64'(bus.out_sum), 64'd5);
            check($sformatf("bp_in_ready_%0d", i), 64'(bus.in_ready), 64'd0);
            check($sformatf("bp_busy_%0d", i), 64'(bus.busy), 64'd1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        check("bp_release_valid", 64'(bus.out_valid), 64'd0);
        check("bp_release_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("bp_no_restart", 64'(bus.busy), 64'd0);

        sb.push_back('{sum: 32'd0, sat: 1'b0});
        start_burst(8'd0);
        expect_result("len0", 1'b1, 1'b1);

        sb.push_back('{sum: 32'd4, sat: 1'b0});
        start_burst(8'd4);
        send(64'h10000, 0);
        send(64'h10000, 0);
        send(64'h10000, 3);
        send(64'h10000, 1);
        expect_result("stall", 1'b1, 1'b1);

        // Reset in the middle of a burst discards the partial sum.
        start_burst(8'd4);
        send(64'h10000, 0);
        send(64'h10000, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_out_sum", 64'(bus.out_sum), 64'd0);
        check("mid_rst_out_sat", 64'(bus.out_sat), 64'd0);
        one_shot("after_rst", 64'h30000, 32'd3, 1'b0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
